// File: rtl/add32_accumulator.sv
// Multi-operand accumulator around a 32-bit ripple-carry adder: sums a valid/ready
// operand stream into groups closed by a last beat, with sticky carry/borrow and overflow.

module add32 (
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic        c_in,
    output logic [31:0] s,
    output logic        c_out
);

    logic rc;

    // Bit-serial ripple of the carry from LSB to MSB.
    always_comb begin
        rc = c_in;
        s  = '0;
        for (int i = 0; i < 32; i++) begin
            s[i] = a[i] ^ b[i] ^ rc;
            rc   = (a[i] & b[i]) | (rc & (a[i] ^ b[i]));
        end
        c_out = rc;
    end

endmodule

module add32_accumulator #(
    parameter int unsigned N     = 32,
    parameter int unsigned CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [N-1:0]     in_data,
    input  logic             in_sub,
    input  logic             in_last,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [N-1:0]     out_sum,
    output logic             out_carry,
    output logic             out_overflow,
    output logic [CNT_W-1:0] out_count
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    typedef enum logic {
        S_ACC  = 1'b0,
        S_DONE = 1'b1
    } state_t;

    state_t             state_q, state_d;
    logic [N-1:0]       acc_q, acc_d;
    logic               carry_q, carry_d;
    logic               ovf_q, ovf_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               in_ready_q, in_ready_d;
    logic               out_valid_q, out_valid_d;

    logic [N-1:0]       add_b;
    logic [N-1:0]       add_s;
    logic               add_c;
    logic               accept;

    // Subtraction is a + ~b + 1, so the adder carry-in doubles as the sub select.
    assign add_b  = in_sub ? ~in_data : in_data;
    assign accept = in_valid && in_ready_q;

    add32 u_add32 (
        .a     (acc_q),
        .b     (add_b),
        .c_in  (in_sub),
        .s     (add_s),
        .c_out (add_c)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_ACC;
            acc_q       <= '0;
            carry_q     <= 1'b0;
            ovf_q       <= 1'b0;
            cnt_q       <= '0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            acc_q       <= acc_d;
            carry_q     <= carry_d;
            ovf_q       <= ovf_d;
            cnt_q       <= cnt_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
        end
    end

    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        carry_d = carry_q;
        ovf_d   = ovf_q;
        cnt_d   = cnt_q;

        case (state_q)
            S_ACC: begin
                if (accept) begin
                    acc_d   = add_s;
                    // On subtract, a missing carry-out means a borrow occurred.
                    carry_d = carry_q | (in_sub ? ~add_c : add_c);
                    ovf_d   = ovf_q | ((acc_q[N-1] == add_b[N-1]) && (add_s[N-1] != acc_q[N-1]));
                    cnt_d   = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CNT_W'(1);
                    if (in_last) begin
                        state_d = S_DONE;
                    end
                end
            end
            S_DONE: begin
                if (out_ready) begin
                    acc_d   = '0;
                    carry_d = 1'b0;
                    ovf_d   = 1'b0;
                    cnt_d   = '0;
                    state_d = S_ACC;
                end
            end
            default: begin
                state_d = S_ACC;
            end
        endcase

        in_ready_d  = (state_d == S_ACC);
        out_valid_d = (state_d == S_DONE);
    end

    assign in_ready     = in_ready_q;
    assign out_valid    = out_valid_q;
    assign out_sum      = acc_q;
    assign out_carry    = carry_q;
    assign out_overflow = ovf_q;
    assign out_count    = cnt_q;

endmodule

// File: tb/tb_add32_accumulator.sv
// Self-checking bench for add32_accumulator: directed and randomized groups compared
// against an arithmetic reference model of signed/unsigned group sums.

module tb_add32_accumulator;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_data;
    logic        in_sub;
    logic        in_last;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_sum;
    logic        out_carry;
    logic        out_overflow;
    logic [7:0]  out_count;

    int checks   = 0;
    int failures = 0;

    logic [31:0] q_data[$];
    bit          q_sub[$];

    logic [31:0] obs_sum;
    logic        obs_carry;
    logic        obs_ovf;
    logic [7:0]  obs_count;

    add32_accumulator #(.N(32), .CNT_W(8)) dut (
        .clk          (clk),
        .rst          (rst),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_data      (in_data),
        .in_sub       (in_sub),
        .in_last      (in_last),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_sum      (out_sum),
        .out_carry    (out_carry),
        .out_overflow (out_overflow),
        .out_count    (out_count)
    );

    always #5 clk = ~clk;

    // Reference: exact integer arithmetic over the whole group.
    task automatic model(output logic [31:0] s, output logic c, output logic o,
                         output logic [7:0] cnt);
        longint sa, sd, r;
        int     n;
        s = 32'd0; c = 1'b0; o = 1'b0; n = 0;
        foreach (q_data[i]) begin
            sa = $signed(s);
            sd = $signed(q_data[i]);
            if (q_sub[i]) begin
                r = sa - sd;
                if (s < q_data[i]) c = 1'b1;
                s = s - q_data[i];
            end else begin
                r = sa + sd;
                if ({1'b0, s} + {1'b0, q_data[i]} > 33'h0_FFFF_FFFF) c = 1'b1;
                s = s + q_data[i];
            end
            if (r > 64'sd2147483647 || r < -64'sd2147483648) o = 1'b1;
            n++;
        end
        cnt = (n > 255) ? 8'd255 : 8'(n);
    endtask

    task automatic wait_ready(input string name);
        int t = 0;
        while (in_ready !== 1'b1 && t < 10) begin
            @(negedge clk);
            t++;
        end
        if (in_ready !== 1'b1) begin
            checks++; failures++;
            $display("FAIL %s.in_ready_timeout actual=%b expected=1", name, in_ready);
        end
    endtask

    // Drives q_data/q_sub as one group, then checks the presented result.
    task automatic send_group(input string name);
        logic [31:0] es; logic ec, eo; logic [7:0] en;
        model(es, ec, eo, en);
        foreach (q_data[i]) begin
            @(negedge clk);
            wait_ready(name);
            if (out_valid !== 1'b0) begin
                checks++; failures++;
                $display("FAIL %s.early_valid beat=%0d actual=%b expected=0", name, i, out_valid);
            end
            in_valid = 1'b1;
            in_data  = q_data[i];
            in_sub   = q_sub[i];
            in_last  = (i == q_data.size() - 1);
            @(posedge clk);
        end
        @(negedge clk);
        in_valid = 1'b0;
        in_data  = $urandom;
        in_last  = 1'b0;
        checks++;
        if (out_valid !== 1'b1 || in_ready !== 1'b0) begin
            failures++;
            $display("FAIL %s.handshake actual=v%b/r%b expected=v1/r0", name, out_valid, in_ready);
        end
        checks++;
        if (out_sum !== es) begin
            failures++;
            $display("FAIL %s.sum actual=%h expected=%h", name, out_sum, es);
        end
        checks++;
        if (out_carry !== ec || out_overflow !== eo) begin
            failures++;
            $display("FAIL %s.flags actual=c%b/o%b expected=c%b/o%b", name, out_carry, out_overflow, ec, eo);
        end
        checks++;
        if (out_count !== en) begin
            failures++;
            $display("FAIL %s.count actual=%0d expected=%0d", name, out_count, en);
        end
        obs_sum = out_sum; obs_carry = out_carry; obs_ovf = out_overflow; obs_count = out_count;
    endtask

    task automatic consume(input string name);
        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        out_ready = 1'b0;
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1 || out_sum !== 32'd0 || out_count !== 8'd0) begin
            failures++;
            $display("FAIL %s.consume actual=v%b/r%b/sum%h/cnt%0d expected=v0/r1/sum0/cnt0",
                     name, out_valid, in_ready, out_sum, out_count);
        end
    endtask

    task automatic directed(input string name, input logic [31:0] es, input logic ec,
                            input logic eo, input logic [7:0] en);
        send_group(name);
        checks++;
        if (obs_sum !== es || obs_carry !== ec || obs_ovf !== eo || obs_count !== en) begin
            failures++;
            $display("FAIL %s.directed actual=%h/c%b/o%b/n%0d expected=%h/c%b/o%b/n%0d",
                     name, obs_sum, obs_carry, obs_ovf, obs_count, es, ec, eo, en);
        end
        consume(name);
        q_data.delete(); q_sub.delete();
    endtask

    task automatic test_reset();
        rst = 1'b1; in_valid = 1'b0; in_data = '0; in_sub = 1'b0; in_last = 1'b0; out_ready = 1'b0;
        repeat (2) @(posedge clk);
        #2 rst = 1'b0;
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1 || out_sum !== 32'd0 || out_count !== 8'd0
            || out_carry !== 1'b0 || out_overflow !== 1'b0) begin
            failures++;
            $display("FAIL reset actual=v%b/r%b/sum%h/cnt%0d/c%b/o%b expected=v0/r1/0/0/0/0",
                     out_valid, in_ready, out_sum, out_count, out_carry, out_overflow);
        end
    endtask

    task automatic test_directed();
        q_data = '{32'd5, 32'd7, 32'd10}; q_sub = '{0, 0, 0};
        directed("add3", 32'd22, 1'b0, 1'b0, 8'd3);
        q_data = '{32'hFFFF_FFFF, 32'h1}; q_sub = '{0, 0};
        directed("wrap", 32'h0, 1'b1, 1'b0, 8'd2);
        q_data = '{32'h7FFF_FFFF, 32'h1}; q_sub = '{0, 0};
        directed("ovf", 32'h8000_0000, 1'b0, 1'b1, 8'd2);
        q_data = '{32'd3, 32'd5}; q_sub = '{0, 1};
        directed("borrow", 32'hFFFF_FFFE, 1'b1, 1'b0, 8'd2);
        q_data = '{32'd9}; q_sub = '{1};
        directed("lead_sub", 32'hFFFF_FFF7, 1'b1, 1'b0, 8'd1);
        q_data = '{32'h8000_0000}; q_sub = '{1};
        directed("sub_min", 32'h8000_0000, 1'b1, 1'b1, 8'd1);
    endtask

    task automatic test_saturation();
        for (int i = 0; i < 300; i++) begin
            q_data.push_back(32'd1); q_sub.push_back(1'b0);
        end
        directed("saturate", 32'd300, 1'b0, 1'b0, 8'd255);
    endtask

    task automatic test_backpressure();
        logic [31:0] s0;
        for (int i = 0; i < 3; i++) begin
            q_data.push_back($urandom); q_sub.push_back(1'($urandom));
        end
        send_group("bp");
        s0 = out_sum;
        in_valid = 1'b1; in_data = $urandom; in_last = 1'b1;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            in_data = $urandom;
            checks++;
            if (in_ready !== 1'b0 || out_valid !== 1'b1 || out_sum !== s0 || out_count !== 8'd3) begin
                failures++;
                $display("FAIL bp.hold cyc=%0d actual=r%b/v%b/%h/%0d expected=r0/v1/%h/3",
                         k, in_ready, out_valid, out_sum, out_count, s0);
            end
        end
        in_valid = 1'b0; in_last = 1'b0;
        consume("bp");
        q_data.delete(); q_sub.delete();
        q_data = '{32'd100, 32'd23}; q_sub = '{0, 0};
        directed("bp_fresh", 32'd123, 1'b0, 1'b0, 8'd2);
    endtask

    task automatic test_reset_mid();
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            in_valid = 1'b1; in_data = 32'd40 + 32'(i); in_sub = 1'b0; in_last = 1'b0;
            @(posedge clk);
        end
        @(negedge clk);
        in_valid = 1'b0;
        #1 rst = 1'b1;
        #1;
        checks++;
        if (out_sum !== 32'd0 || out_count !== 8'd0 || out_valid !== 1'b0) begin
            failures++;
            $display("FAIL rst_mid actual=%h/%0d/v%b expected=0/0/v0", out_sum, out_count, out_valid);
        end
        @(posedge clk);
        #2 rst = 1'b0;
        q_data = '{32'd1, 32'd2}; q_sub = '{0, 0};
        send_group("rst_done");
        #1 rst = 1'b1;
        #1;
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1 || out_count !== 8'd0) begin
            failures++;
            $display("FAIL rst_done actual=v%b/r%b/%0d expected=v0/r1/0", out_valid, in_ready, out_count);
        end
        @(posedge clk);
        #2 rst = 1'b0;
        q_data.delete(); q_sub.delete();
        q_data = '{32'd6}; q_sub = '{0};
        directed("post_rst", 32'd6, 1'b0, 1'b0, 8'd1);
    endtask

    task automatic test_back_to_back();
        for (int g = 0; g < 20; g++) begin
            int n = $urandom_range(1, 6);
            for (int i = 0; i < n; i++) begin
                q_data.push_back((g % 4 == 0) ? 32'h7FFF_FFF0 + 32'($urandom_range(0, 31)) : $urandom);
                q_sub.push_back(1'($urandom));
            end
            send_group($sformatf("rand%0d", g));
            consume($sformatf("rand%0d", g));
            q_data.delete(); q_sub.delete();
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_saturation();
        test_backpressure();
        test_reset_mid();
        test_back_to_back();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
